// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code path: prefix byte values and the
// sequencer state encoding.
package ps2_pkg;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_timeout_cnt.sv
// Prefix timeout counter. Counts enabled cycles since the last clear and
// raises expire on the last allowed cycle (count = TIMEOUT_CYC-1). A clear in
// the same cycle always wins, so a byte arriving on the final cycle is never
// reported as a timeout.
module ps2_timeout_cnt #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int TIMEOUT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] cnt;

    assign expire = enable && !clear && (cnt == LAST);

    // Count while enabled; restart on clear or when the limit is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 scan-code sequencer. Takes bytes from the PS/2 receiver, strips the
// E0 (extended) and F0 (break) prefixes, and loads only complete make codes
// into the downstream data register. Presents a dato_listo/ack handshake to
// the consumer and flags a sticky overrun when an unread code is replaced.
//
// Handshake: dato_listo rises in the cycle reg_en is issued and stays high
// until the consumer pulses ack; the flag drops the cycle after ack. An ack
// while dato_listo is low has no effect. A load coinciding with ack keeps
// dato_listo high and does not count as an overrun.
//
// Optional build macro REPEAT_FILTER_EN: drops typematic repeats (a make
// identical to the last accepted make) until the matching break is seen.
//
// The current FSM state is exported on dbg_state for observation.
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int TIMEOUT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       ack,
    output logic       reg_en,
    output logic [7:0] code_out,
    output logic       ext_code,
    output logic       dato_listo,
    output logic       overrun,
    output logic       brk_tick,
    output logic [1:0] dbg_state
);

    ps2_state_t state, state_n;

    logic make_ev;   // a complete make code is present on rx_data
    logic make_ext;  // that make code was E0-prefixed
    logic brk_ev;    // a break sequence completes with rx_data
    logic brk_ext;   // that break was E0-prefixed
    logic load;      // make code accepted for loading
    logic tmo_clear;
    logic tmo_en;
    logic tmo_expire;

    assign dbg_state = state;

    // Prefix timeout runs only while waiting for the byte after a prefix.
    assign tmo_clear = rx_done_tick || (state == IDLE);
    assign tmo_en    = (state != IDLE);

    ps2_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TIMEOUT_W   (TIMEOUT_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmo_clear),
        .enable (tmo_en),
        .expire (tmo_expire)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Prefix decode: next state and make/break events for the current byte.
    always_comb begin
        state_n  = state;
        make_ev  = 1'b0;
        make_ext = 1'b0;
        brk_ev   = 1'b0;
        brk_ext  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_done_tick) begin
                    if (rx_data == CODE_EXT) begin
                        state_n = EXT;
                    end else if (rx_data == CODE_BRK) begin
                        state_n = BRK;
                    end else begin
                        make_ev = 1'b1;
                    end
                end
            end
            EXT: begin
                if (rx_done_tick) begin
                    if (rx_data == CODE_EXT) begin
                        state_n = EXT;
                    end else if (rx_data == CODE_BRK) begin
                        state_n = EXT_BRK;
                    end else begin
                        make_ev  = 1'b1;
                        make_ext = 1'b1;
                        state_n  = IDLE;
                    end
                end else if (tmo_expire) begin
                    state_n = IDLE;
                end
            end
            BRK: begin
                if (rx_done_tick) begin
                    if (rx_data != CODE_BRK) begin
                        brk_ev  = 1'b1;
                        state_n = IDLE;
                    end
                end else if (tmo_expire) begin
                    state_n = IDLE;
                end
            end
            EXT_BRK: begin
                if (rx_done_tick) begin
                    if (rx_data != CODE_BRK) begin
                        brk_ev  = 1'b1;
                        brk_ext = 1'b1;
                        state_n = IDLE;
                    end
                end else if (tmo_expire) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef REPEAT_FILTER_EN
    logic [8:0] last_make;
    logic       repeat_hit;

    assign repeat_hit = ({make_ext, rx_data} == last_make);
    assign load       = make_ev && !repeat_hit;

    // Remember the last accepted make; forget it once its break is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_make <= '0;
        end else if (load) begin
            last_make <= {make_ext, rx_data};
        end else if (brk_ev && ({brk_ext, rx_data} == last_make)) begin
            last_make <= '0;
        end
    end
`else
    assign load = make_ev;
`endif

    // Registered outputs toward the data register: one-cycle strobes and the
    // code/extended flag, which only change when a load is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_en   <= 1'b0;
            brk_tick <= 1'b0;
            code_out <= '0;
            ext_code <= 1'b0;
        end else begin
            reg_en   <= load;
            brk_tick <= brk_ev;
            if (load) begin
                code_out <= rx_data;
                ext_code <= make_ext;
            end
        end
    end

    // Consumer handshake and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dato_listo <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                dato_listo <= 1'b1;
            end else if (ack) begin
                dato_listo <= 1'b0;
            end

            if (load && dato_listo && !ack) begin
                overrun <= 1'b1;
            end else if (ack) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
